// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer driving the ALU, PC and status register
module instr_sequencer #(
  parameter int          PC_W    = 12,
  parameter logic [5:0]  LAST_OP = 6'h38
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     instruction,
  output logic [5:0]      encoded_opcode,
  output logic            exec1,
  output logic            exec2,
  output logic [2:0]      rs1_addr,
  output logic [2:0]      rs2_addr,
  input  logic [15:0]     rs1data,
  input  logic [15:0]     aluout1,
  input  logic [15:0]     aluout2,
  input  logic [7:0]      alu_status,
  output logic [7:0]      status,
  output logic            reg_we,
  output logic [2:0]      reg_waddr,
  output logic [15:0]     reg_wdata,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC1  = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [5:0] OP_JMR = 6'h00;
  localparam logic [5:0] OP_JMI = 6'h01;
  localparam logic [5:0] OP_JEQ = 6'h02;
  localparam logic [5:0] OP_MUL = 6'h21;
  localparam logic [5:0] OP_STP = 6'h27;
  localparam logic [5:0] OP_FLG_LO = 6'h29;
  localparam logic [5:0] OP_FLG_HI = 6'h36;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      status_q, status_d;

  logic [5:0] op;
  logic [5:0] flg_off;
  logic       wb_op;
  logic       unused_ok;

  assign op      = ir_q[15:10];
  assign flg_off = op - OP_FLG_LO;
  assign wb_op   = (op >= 6'h03 && op <= 6'h09) || (op >= 6'h11 && op <= 6'h18) ||
                   (op >= 6'h1D && op <= 6'h1F) || (op == OP_MUL);

  assign unused_ok = ^{rs1data[15:PC_W], alu_status[7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    status_d  = status_q;
    mem_req   = 1'b0;
    exec1     = 1'b0;
    exec2     = 1'b0;
    reg_we    = 1'b0;
    reg_waddr = ir_q[9:7];
    reg_wdata = aluout1;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // reset gating keeps the request low the instant reset rises
        mem_req = !reset;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        exec1   = 1'b1;
        state_d = (op == OP_MUL) ? S_EXEC2 : S_FETCH;
        if (op > LAST_OP) begin
          illegal = 1'b1;
        end else if (wb_op) begin
          reg_we   = 1'b1;
          status_d = alu_status & 8'h7F;
        end else if (op >= OP_FLG_LO && op <= OP_FLG_HI) begin
          // pairs of ops per flag: even offset sets, odd offset clears
          status_d[flg_off[3:1]] = ~flg_off[0];
        end else if (op == OP_JMR) begin
          pc_d = rs1data[PC_W-1:0];
        end else if (op == OP_JMI) begin
          pc_d = ir_q[PC_W-1:0];
        end else if (op == OP_JEQ && status_q[0]) begin
          pc_d = ir_q[PC_W-1:0];
        end else if (op == OP_STP) begin
          state_d = S_HALT;
        end
      end
      S_EXEC2: begin
        exec2     = 1'b1;
        reg_we    = 1'b1;
        reg_waddr = ir_q[9:7] + 3'd1;
        reg_wdata = aluout2;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_addr       = pc_q;
  assign pc             = pc_q;
  assign instruction    = ir_q;
  assign encoded_opcode = op;
  assign rs1_addr       = ir_q[6:4];
  assign rs2_addr       = ir_q[3:1];
  assign status         = status_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic [5:0]  encoded_opcode;
  logic        exec1, exec2;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] rs1data, aluout1, aluout2;
  logic [7:0]  alu_status, status;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [11:0] pc;
  logic        halted, illegal;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instruction(instruction), .encoded_opcode(encoded_opcode),
    .exec1(exec1), .exec2(exec2), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1data(rs1data),
    .aluout1(aluout1), .aluout2(aluout2), .alu_status(alu_status), .status(status),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .pc(pc),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_pc;
  logic [7:0]  exp_status;
  logic [15:0] jeq_w;

  // write-back scoreboard
  always @(negedge clk) begin
    if (!reset && reg_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", reg_waddr, reg_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (reg_waddr !== mon_e.a || reg_wdata !== mon_e.d) begin
          errors++;
          $display("FAIL write_back: got addr=%0d data=%h, expected addr=%0d data=%h",
                   reg_waddr, reg_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic do_fetch(input logic [15:0] w);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: mem_req=%b, expected 1", mem_req);
    end
    checks++;
    if (mem_addr !== exp_pc) begin
      errors++;
      $display("FAIL fetch_addr: got %h, expected %h", mem_addr, exp_pc);
    end
    mem_rdata = w;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    exp_pc    = exp_pc + 12'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; rs1data = 16'h0;
    aluout1 = 16'h0; aluout2 = 16'h0; alu_status = 8'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pc, status, instruction, mem_req, exec1, exec2, reg_we, halted, illegal} !== 42'h0) begin
      errors++;
      $display("FAIL reset_state: pc=%h status=%h ir=%h req=%b e1=%b e2=%b we=%b halt=%b ill=%b, expected all 0",
               pc, status, instruction, mem_req, exec1, exec2, reg_we, halted, illegal);
    end
    reset = 1'b0;
    @(negedge clk);
    exp_pc = 12'h000;
    exp_status = 8'h00;
  endtask

  task automatic test_add;
    aluout1 = 16'h1234; alu_status = 8'hFF;
    exp_q.push_back('{3'd1, 16'h1234});
    do_fetch(16'h44A6);
    checks++;
    if (mem_req !== 1'b0 || exec1 !== 1'b0 || encoded_opcode !== 6'h11 || rs1_addr !== 3'd2 || rs2_addr !== 3'd3) begin
      errors++;
      $display("FAIL add_decode: req=%b e1=%b op=%h rs1=%0d rs2=%0d, expected 0 0 11 2 3",
               mem_req, exec1, encoded_opcode, rs1_addr, rs2_addr);
    end
    @(negedge clk);
    checks++;
    if (exec1 !== 1'b1 || reg_we !== 1'b1) begin
      errors++;
      $display("FAIL add_exec1: e1=%b we=%b, expected 1 1", exec1, reg_we);
    end
    exp_status = 8'h7F;
    @(negedge clk);
    checks++;
    if (status !== exp_status || exec1 !== 1'b0 || pc !== exp_pc) begin
      errors++;
      $display("FAIL add_after: status=%h e1=%b pc=%h, expected %h 0 %h", status, exec1, pc, exp_status, exp_pc);
    end
  endtask

  task automatic test_fetch_wait;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_pc || exec1 !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait: req=%b addr=%h e1=%b, expected 1 %h 0", mem_req, mem_addr, exec1, exp_pc);
      end
      @(negedge clk);
    end
    do_fetch(16'h8800);
    @(negedge clk);
    checks++;
    if (exec1 !== 1'b1 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL nop_exec: e1=%b we=%b, expected 1 0", exec1, reg_we);
    end
    @(negedge clk);
    checks++;
    if (status !== exp_status) begin
      errors++;
      $display("FAIL nop_status: got %h, expected %h", status, exp_status);
    end
  endtask

  task automatic test_mul;
    aluout1 = 16'hAAAA; aluout2 = 16'h5555; alu_status = 8'h83;
    exp_q.push_back('{3'd7, 16'hAAAA});
    exp_q.push_back('{3'd0, 16'h5555});
    do_fetch(16'h8780);
    @(negedge clk);
    checks++;
    if (exec1 !== 1'b1 || exec2 !== 1'b0) begin
      errors++;
      $display("FAIL mul_exec1: e1=%b e2=%b, expected 1 0", exec1, exec2);
    end
    @(negedge clk);
    exp_status = 8'h03;
    checks++;
    if (exec2 !== 1'b1 || exec1 !== 1'b0 || encoded_opcode !== 6'h21) begin
      errors++;
      $display("FAIL mul_exec2: e1=%b e2=%b op=%h, expected 0 1 21", exec1, exec2, encoded_opcode);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_pc || status !== exp_status) begin
      errors++;
      $display("FAIL mul_next: req=%b addr=%h status=%h, expected 1 %h %h", mem_req, mem_addr, status, exp_pc, exp_status);
    end
  endtask

  task automatic test_jeq;
    jeq_w = {6'h02, 10'h0A5};
    do_fetch(jeq_w);
    repeat (2) @(negedge clk);
    exp_pc = jeq_w[11:0];
    checks++;
    if (mem_addr !== exp_pc) begin
      errors++;
      $display("FAIL jeq_taken: addr=%h, expected %h", mem_addr, exp_pc);
    end
    do_fetch(16'hA800);
    repeat (2) @(negedge clk);
    exp_status = exp_status & 8'hFE;
    checks++;
    if (status !== exp_status) begin
      errors++;
      $display("FAIL clz_status: got %h, expected %h", status, exp_status);
    end
    do_fetch(jeq_w);
    repeat (2) @(negedge clk);
    checks++;
    if (mem_addr !== exp_pc) begin
      errors++;
      $display("FAIL jeq_not_taken: addr=%h, expected %h", mem_addr, exp_pc);
    end
  endtask

  task automatic test_flags;
    do_fetch(16'hB400);
    repeat (2) @(negedge clk);
    exp_status = exp_status | 8'h04;
    checks++;
    if (status !== exp_status) begin
      errors++;
      $display("FAIL sec_status: got %h, expected %h", status, exp_status);
    end
    do_fetch(16'hB800);
    repeat (2) @(negedge clk);
    exp_status = exp_status & 8'hFB;
    checks++;
    if (status !== exp_status) begin
      errors++;
      $display("FAIL clc_status: got %h, expected %h", status, exp_status);
    end
  endtask

  task automatic test_wrap;
    rs1data = 16'hAFFF;
    do_fetch(16'h0010);
    repeat (2) @(negedge clk);
    exp_pc = 12'hFFF;
    checks++;
    if (mem_addr !== exp_pc) begin
      errors++;
      $display("FAIL jmr_target: addr=%h, expected %h", mem_addr, exp_pc);
    end
    do_fetch(16'h8800);
    checks++;
    if (pc !== 12'h000 || exp_pc !== 12'h000) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, expected 000", pc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal;
    do_fetch(16'hFC00);
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || reg_we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b we=%b, expected 1 0", illegal, reg_we);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || status !== exp_status) begin
      errors++;
      $display("FAIL illegal_after: ill=%b status=%h, expected 0 %h", illegal, status, exp_status);
    end
    do_fetch(16'hE000);
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || exec1 !== 1'b1) begin
      errors++;
      $display("FAIL last_op_legal: ill=%b e1=%b, expected 0 1", illegal, exec1);
    end
    @(negedge clk);
  endtask

  task automatic test_halt;
    do_fetch(16'h9C00);
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: halted=%b req=%b, expected 1 0", halted, mem_req);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== exp_pc || exec1 !== 1'b0 || mem_req !== 1'b0 || status !== exp_status) begin
      errors++;
      $display("FAIL halt_frozen: pc=%h e1=%b req=%b status=%h, expected %h 0 0 %h",
               pc, exec1, mem_req, status, exp_pc, exp_status);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || pc !== 12'h000) begin
      errors++;
      $display("FAIL halt_reset: halted=%b pc=%h, expected 0 000", halted, pc);
    end
    reset = 1'b0;
    @(negedge clk);
    exp_pc = 12'h000;
    exp_status = 8'h00;
  endtask

  task automatic test_reset_midfetch;
    do_fetch(16'h8800);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h, expected 0 000", mem_req, pc);
    end
    @(negedge clk);
    mem_rdata = 16'h44A6;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    reset = 1'b0;
    exp_pc = 12'h000;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000 || instruction !== 16'h0) begin
      errors++;
      $display("FAIL late_ack: req=%b addr=%h ir=%h, expected 1 000 0000", mem_req, mem_addr, instruction);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_fetch_wait;
    test_mul;
    test_jeq;
    test_flags;
    test_wrap;
    test_illegal;
    test_halt;
    test_reset_midfetch;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
